multadd_sched: RTL
==================

# multadd_sched

Round-robin scheduler that shares one pipelined multiply-add datapath (y from x1, x2, x3; fixed DP_LAT-cycle latency, no handshake) between two requesters. It issues at most one operation per cycle and tags each in-flight operation with its requester id. Results are returned through a single valid/ready response channel backed by a small FIFO. Credit-based issue control guarantees that the FIFO never overflows under response backpressure.

## Interface

Parameters:
- W, 10: operand/result width
- DP_LAT, 2: cycles from operands presented on dp_x* to dp_y valid
- FIFO_DEPTH, 4: response FIFO entries (power of two, ≥ DP_LAT+2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_x1, req0_x2, req0_x3  in  W  requester 0 operands
- req1_valid, req1_ready, req1_x1, req1_x2, req1_x3: same for requester 1
- dp_x1, dp_x2, dp_x3  out  W  datapath operands
- dp_y  in  W  datapath result
- resp_valid  out  1  response head valid
- resp_ready  in  1  consumer accepts head
- resp_id  out  1  requester that issued the head result
- resp_y  out  W  result, dp_y unmodified
- busy  out  1  any operation in flight or queued

## Operation

- Occupancy = FIFO count + number of valid tag-pipeline stages. Issue is permitted iff occupancy < FIFO_DEPTH. A pop in the same cycle does not free a credit until the next cycle.
- Arbitration (combinational, same cycle):
  - If issue is permitted and only one requester is valid, that requester is granted.
  - If both are valid, the requester selected by the priority pointer is granted.
  - reqN_ready = grant to N. A transfer occurs on valid&ready. Requesters hold their operands until accepted.
- Priority pointer: reset value selects requester 0. After any grant it points to the requester not granted. It is unchanged when there is no grant.
- dp_x* = granted requester's operands in the issue cycle, else all zeros (bubble).
- Tag pipeline: DP_LAT stages of {valid, id}, shifted every cycle. Stage 0 is loaded with {grant, granted id}. The last stage is aligned with dp_y.
- When the last stage is valid, {id, dp_y} is pushed into the FIFO on that edge. No width change or arithmetic is applied.
- The FIFO is show-ahead. resp_valid = not empty; resp_id/resp_y = head. The head is popped on resp_valid&resp_ready. Push and pop in the same cycle are allowed, including from a count of 1.
- busy = any tag stage valid or FIFO not empty.
- Reset (asynchronous, any time): pointer→0, tag stages invalid, FIFO empty.
  - All outputs go to 0: resp_valid, resp_id, resp_y, busy, req*_ready, dp_x*.
  - In-flight and queued operations are discarded. Requesters must reissue them.

## Timing

- Issue in cycle c → dp_y valid in cycle c+DP_LAT → resp_valid in cycle c+DP_LAT+1 (3 cycles at defaults).
- With resp_ready held high, sustained throughput is 1 issue/cycle (occupancy peaks at DP_LAT+1 < FIFO_DEPTH).
- With resp_ready held low, exactly FIFO_DEPTH issues are accepted, then both readys stay 0 until the cycle after the first pop.
- Results are delivered in issue order. The id interleave equals the grant sequence.

## Structure

- Package multadd_pkg: default W, DP_LAT, FIFO_DEPTH constants; typedef for the requester id; typedef for the FIFO entry {id, y}.
- Sub-module multadd_resp_fifo: show-ahead synchronous FIFO with async reset, count output, push/pop, depth parameter.
- The datapath is instantiated beside this block at the top level, not inside it.

## Test plan

The bench datapath stub is a DP_LAT-stage register chain returning (x1+x2+x3) mod 2^W. A final run against the real datapath uses the existing multadd vector file.

- Single op: after reset, req0 issues 3,4,5 → req0_ready=1 that cycle; dp_x*=3,4,5; resp_valid rises 3 cycles later with resp_id=0, resp_y=12; busy falls after the pop.
- Contention: both requesters valid for 4 cycles, req0 = 1,1,1 and req1 = 2,2,2 → grants 0,1,0,1; responses ids 0,1,0,1 with y 3,6,3,6 in order.
- Backpressure: resp_ready=0, req0 valid continuously → exactly 4 accepts, then req0_ready=0. Raise resp_ready → first pop, req0_ready=1 next cycle, no result lost or duplicated.
- Full throughput: resp_ready=1, 16 back-to-back req1 ops with x3=0..15, x1=x2=0 → req1_ready high every cycle, resp_y=0..15 on consecutive cycles.
- Reset mid-operation: assert reset with 2 in flight and 2 queued → all outputs 0 immediately (before next edge). After release, no stale response appears and the pointer favours req0.
- Real datapath: every vector in the file issued alternately from req0/req1 → all resp_y match the expected column, error count 0.

Source files
------------

// File: rtl/multadd_pkg.sv
// rtl/multadd_pkg.sv - shared defaults and types for the multiply-add scheduler
package multadd_pkg;

  localparam int DEF_W          = 10;
  localparam int DEF_DP_LAT     = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic req_id_t;

  typedef struct packed {
    req_id_t            id;
    logic [DEF_W-1:0]   y;
  } resp_entry_t;

endpackage

// File: rtl/multadd_resp_fifo.sv
// rtl/multadd_resp_fifo.sv - show-ahead response FIFO with occupancy count
module multadd_resp_fifo
  import multadd_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int DATA_W = $bits(resp_entry_t),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/multadd_sched.sv
// rtl/multadd_sched.sv - round-robin, credit-limited sharing of one multiply-add datapath
module multadd_sched
  import multadd_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int DP_LAT     = DEF_DP_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_x1,
  input  logic [W-1:0] req0_x2,
  input  logic [W-1:0] req0_x3,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_x1,
  input  logic [W-1:0] req1_x2,
  input  logic [W-1:0] req1_x3,
  output logic [W-1:0] dp_x1,
  output logic [W-1:0] dp_x2,
  output logic [W-1:0] dp_x3,
  input  logic [W-1:0] dp_y,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_y,
  output logic         busy
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW  = $clog2(FIFO_DEPTH + DP_LAT + 1) + 1;

  req_id_t             ptr;
  logic [DP_LAT-1:0]   tag_valid;
  logic [DP_LAT-1:0]   tag_id;
  logic [OCW-1:0]      occupancy;
  logic                issue_ok;
  logic                grant0;
  logic                grant1;
  logic [CNTW-1:0]     fifo_count;
  logic                fifo_empty;
  logic [W:0]          fifo_head;

  // Every issued op holds a credit from issue until its FIFO entry is popped.
  always_comb begin
    occupancy = OCW'(fifo_count);
    for (int i = 0; i < DP_LAT; i++) occupancy = occupancy + OCW'(tag_valid[i]);
  end

  assign issue_ok = occupancy < OCW'(FIFO_DEPTH);

  // Gating with reset keeps the combinational outputs quiet while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && issue_ok) begin
      if (req0_valid && (!req1_valid || ptr == 1'b0)) grant0 = 1'b1;
      else if (req1_valid)                           grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    dp_x1 = '0;
    dp_x2 = '0;
    dp_x3 = '0;
    if (grant0) begin
      dp_x1 = req0_x1;
      dp_x2 = req0_x2;
      dp_x3 = req0_x3;
    end else if (grant1) begin
      dp_x1 = req1_x1;
      dp_x2 = req1_x2;
      dp_x3 = req1_x3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      if (grant0)      ptr <= 1'b1;
      else if (grant1) ptr <= 1'b0;
      tag_valid[0] <= grant0 | grant1;
      tag_id[0]    <= grant1;
      for (int i = 1; i < DP_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  multadd_resp_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_valid[DP_LAT-1]),
    .push_data ({tag_id[DP_LAT-1], dp_y}),
    .pop       (resp_valid && resp_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The head storage is never cleared, so mask it whenever nothing is queued.
  assign resp_valid = !fifo_empty;
  assign resp_id    = fifo_empty ? 1'b0 : fifo_head[W];
  assign resp_y     = fifo_empty ? '0   : fifo_head[W-1:0];
  assign busy       = (|tag_valid) || !fifo_empty;

endmodule
